// File: rtl/ram_port_arbiter.sv
// Arbiter for the single shared RAM port: round-robin between two cores, data over fetch,
// with a starvation guard for fetches and a timeout on every held grant.
module ram_port_arbiter #(
  parameter int MAXWAIT = 4,
  parameter int TIMEOUT = 64
) (
  input  logic       CLK,
  input  logic       nRST,
  input  logic [1:0] dreq,
  input  logic [1:0] dwr,
  input  logic [1:0] ireq,
  input  logic [1:0] ramstate,
  output logic       gnt_valid,
  output logic       gnt_core,
  output logic       gnt_isdata,
  output logic       gnt_wen,
  output logic       done,
  output logic       err
);

  typedef enum logic [1:0] {FREE, BUSY, ACCESS, ERROR} ramstate_t;
  typedef enum logic {IDLE, GRANT} state_t;

  localparam logic [3:0] SMAX  = 4'(MAXWAIT);
  localparam logic [7:0] TLAST = 8'(TIMEOUT - 1);

  state_t     state, state_n;
  ramstate_t  rs;
  logic       core_n, isd_n;
  logic       rr_d, rr_i, rrd_n, rri_n;
  logic [3:0] scnt, scnt_n;
  logic [7:0] tcnt, tcnt_n;
  logic       err_n;
  logic       any_d, any_i, starve, sel_d, sel_i, reqline;

  // Both cores asking: follow the class pointer; otherwise the single requester wins.
  function automatic logic pick(input logic [1:0] r, input logic ptr);
    return (r == 2'b11) ? ptr : r[1];
  endfunction

  assign rs      = ramstate_t'(ramstate);
  assign any_d   = |dreq;
  assign any_i   = |ireq;
  assign starve  = (scnt == SMAX) && any_i;
  assign sel_d   = pick(dreq, rr_d);
  assign sel_i   = pick(ireq, rr_i);
  assign reqline = gnt_isdata ? dreq[gnt_core] : ireq[gnt_core];

  assign gnt_valid = (state == GRANT);
  assign gnt_wen   = gnt_valid & gnt_isdata & dwr[gnt_core];

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state      <= IDLE;
      gnt_core   <= 1'b0;
      gnt_isdata <= 1'b0;
      rr_d       <= 1'b0;
      rr_i       <= 1'b0;
      scnt       <= '0;
      tcnt       <= '0;
      err        <= 1'b0;
    end else begin
      state      <= state_n;
      gnt_core   <= core_n;
      gnt_isdata <= isd_n;
      rr_d       <= rrd_n;
      rr_i       <= rri_n;
      scnt       <= scnt_n;
      tcnt       <= tcnt_n;
      err        <= err_n;
    end
  end

  always_comb begin
    state_n = state;
    core_n  = gnt_core;
    isd_n   = gnt_isdata;
    rrd_n   = rr_d;
    rri_n   = rr_i;
    scnt_n  = scnt;
    tcnt_n  = tcnt;
    err_n   = 1'b0;
    done    = 1'b0;
    case (state)
      IDLE: begin
        if (starve || (!any_d && any_i)) begin
          core_n  = sel_i;
          isd_n   = 1'b0;
          rri_n   = ~sel_i;
          scnt_n  = '0;
          tcnt_n  = '0;
          state_n = GRANT;
        end else if (any_d) begin
          core_n  = sel_d;
          isd_n   = 1'b1;
          rrd_n   = ~sel_d;
          if (any_i && (scnt != SMAX))
            scnt_n = scnt + 4'd1;
          tcnt_n  = '0;
          state_n = GRANT;
        end
      end
      GRANT: begin
        // A withdrawn request is an abort: neither done nor err is reported.
        if (!reqline) begin
          state_n = IDLE;
        end else if (rs == ERROR) begin
          err_n   = 1'b1;
          state_n = IDLE;
        end else if (rs == ACCESS) begin
          done    = 1'b1;
          state_n = IDLE;
        end else if (tcnt == TLAST) begin
          err_n   = 1'b1;
          state_n = IDLE;
        end else begin
          tcnt_n = tcnt + 8'd1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter: per-cycle vector table plus hand-written
// sequences for starvation, timeout, ACCESS-vs-timeout and reset mid-grant.
module tb_ram_port_arbiter;

  localparam logic [1:0] FREE = 2'd0, BUSY = 2'd1, ACC = 2'd2, ERR = 2'd3;

  logic       CLK = 1'b0;
  logic       nRST;
  logic [1:0] dreq, dwr, ireq, ramstate;
  logic       gnt_valid, gnt_core, gnt_isdata, gnt_wen, done, err;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [1:0] dreq;
    logic [1:0] dwr;
    logic [1:0] ireq;
    logic [1:0] rs;
    logic [5:0] exp;
  } vec_t;

  vec_t vecs[$];

  ram_port_arbiter #(.MAXWAIT(4), .TIMEOUT(64)) dut (
    .CLK(CLK), .nRST(nRST), .dreq(dreq), .dwr(dwr), .ireq(ireq), .ramstate(ramstate),
    .gnt_valid(gnt_valid), .gnt_core(gnt_core), .gnt_isdata(gnt_isdata),
    .gnt_wen(gnt_wen), .done(done), .err(err)
  );

  always #5 CLK = ~CLK;

  task automatic addVec(input logic [1:0] d, input logic [1:0] w, input logic [1:0] i,
                        input logic [1:0] r, input logic [5:0] e);
    vec_t v;
    v.dreq = d; v.dwr = w; v.ireq = i; v.rs = r; v.exp = e;
    vecs.push_back(v);
  endtask

  task automatic applyStimulus(input logic [1:0] d, input logic [1:0] w,
                               input logic [1:0] i, input logic [1:0] r);
    dreq = d; dwr = w; ireq = i; ramstate = r;
  endtask

  task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  function automatic logic [5:0] outs();
    return {gnt_valid, gnt_core, gnt_isdata, gnt_wen, done, err};
  endfunction

  initial begin
    int  cnt;
    logic sawdone;

    // exp = {gnt_valid, gnt_core, gnt_isdata, gnt_wen, done, err}
    addVec(2'b00, 2'b00, 2'b00, FREE, 6'b000000);
    addVec(2'b11, 2'b10, 2'b00, ACC,  6'b000000);
    addVec(2'b11, 2'b10, 2'b00, ACC,  6'b101010);
    addVec(2'b11, 2'b10, 2'b00, ACC,  6'b001000);
    addVec(2'b11, 2'b10, 2'b00, ACC,  6'b111110);
    addVec(2'b11, 2'b10, 2'b00, ACC,  6'b011000);
    addVec(2'b11, 2'b10, 2'b00, ACC,  6'b101010);
    addVec(2'b11, 2'b10, 2'b00, ACC,  6'b001000);
    addVec(2'b11, 2'b10, 2'b00, ACC,  6'b111110);
    addVec(2'b01, 2'b01, 2'b00, BUSY, 6'b011000);
    addVec(2'b01, 2'b01, 2'b00, BUSY, 6'b101100);
    addVec(2'b01, 2'b01, 2'b00, BUSY, 6'b101100);
    addVec(2'b01, 2'b01, 2'b00, ACC,  6'b101110);
    addVec(2'b00, 2'b00, 2'b00, FREE, 6'b001000);
    addVec(2'b00, 2'b00, 2'b01, BUSY, 6'b001000);
    addVec(2'b00, 2'b00, 2'b01, BUSY, 6'b100000);
    addVec(2'b00, 2'b00, 2'b00, BUSY, 6'b100000);
    addVec(2'b00, 2'b00, 2'b00, FREE, 6'b000000);
    addVec(2'b00, 2'b00, 2'b00, FREE, 6'b000000);
    addVec(2'b10, 2'b00, 2'b00, BUSY, 6'b000000);
    addVec(2'b10, 2'b00, 2'b00, ERR,  6'b111000);
    addVec(2'b00, 2'b00, 2'b00, FREE, 6'b011001);
    addVec(2'b00, 2'b00, 2'b00, FREE, 6'b011000);

    nRST = 1'b0;
    applyStimulus(2'b00, 2'b00, 2'b00, FREE);
    repeat (2) @(posedge CLK);
    #1 checkOutput("in_reset", 8'(outs()), 8'h00);
    @(negedge CLK) nRST = 1'b1;
    @(posedge CLK); #1;

    foreach (vecs[k]) begin
      applyStimulus(vecs[k].dreq, vecs[k].dwr, vecs[k].ireq, vecs[k].rs);
      @(negedge CLK);
      checkOutput($sformatf("vec%0d", k), 8'(outs()), 8'(vecs[k].exp));
      @(posedge CLK); #1;
    end

    // Four data grants to core 0, then a forced fetch to core 1, then data again.
    applyStimulus(2'b01, 2'b00, 2'b10, ACC);
    for (int g = 0; g < 6; g++) begin
      logic ec, ed;
      ed = (g != 4);
      ec = (g == 4);
      @(posedge CLK); #1;
      checkOutput($sformatf("starve_grant%0d", g),
                  8'({gnt_valid, gnt_core, gnt_isdata, done}), 8'({1'b1, ec, ed, 1'b1}));
      @(posedge CLK); #1;
      checkOutput($sformatf("starve_gap%0d", g), 8'(gnt_valid), 8'h00);
    end
    applyStimulus(2'b00, 2'b00, 2'b00, BUSY);
    @(posedge CLK); #1;

    // Timeout with RAM stuck BUSY.
    applyStimulus(2'b10, 2'b00, 2'b00, BUSY);
    cnt = 0;
    sawdone = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(posedge CLK); #1;
      if (done) sawdone = 1'b1;
      if (gnt_valid) cnt++;
      else if (cnt > 0) break;
    end
    checkOutput("timeout_len", 8'(cnt), 8'd64);
    checkOutput("timeout_err", 8'(err), 8'h01);
    checkOutput("timeout_nodone", 8'(sawdone), 8'h00);
    @(posedge CLK); #1;
    checkOutput("timeout_regrant", 8'({gnt_valid, gnt_core, gnt_isdata, err}), 8'b1110);

    // ACCESS on the final timeout cycle: done wins, no err.
    repeat (63) @(posedge CLK);
    #1 ramstate = ACC;
    #1 checkOutput("acc_vs_to_done", 8'({gnt_valid, done}), 8'b11);
    @(posedge CLK); #1;
    applyStimulus(2'b00, 2'b00, 2'b00, BUSY);
    checkOutput("acc_vs_to_noerr", 8'({gnt_valid, err}), 8'b00);

    // Reset while a grant is held, then rr_d must be back at core 0.
    applyStimulus(2'b01, 2'b01, 2'b00, BUSY);
    @(posedge CLK); #1;
    checkOutput("pre_reset_grant", 8'({gnt_valid, gnt_core, gnt_wen}), 8'b101);
    #2 nRST = 1'b0;
    #1 checkOutput("reset_midgrant", 8'(outs()), 8'h00);
    dreq = 2'b11;
    @(negedge CLK); #1 nRST = 1'b1;
    @(posedge CLK); #1;
    checkOutput("post_reset_rr", 8'({gnt_valid, gnt_core, gnt_isdata}), 8'b101);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
